half_adder: RTL and testbench

- Bitwise half adder over a WIDTH-bit vector.
- Provides combinational sum/carry outputs that settle within one time step and are independent of the clock.
- Also provides a one-cycle registered copy with a valid flag.
- Leaf arithmetic primitive, used directly or as a building block for wider adders and counters.

---
 rtl/half_adder_pkg.sv | 21 ++
 rtl/half_adder_bit.sv | 17 +
 rtl/half_adder.sv | 78 +++++++
 tb/tb_half_adder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/half_adder_pkg.sv
// Shared types and defaults for the half_adder slice: lane result struct and
// the single-lane evaluation function used by the bit cell.
package half_adder_pkg;

   localparam int HA_DEFAULT_WIDTH = 1;
   localparam int HA_DEFAULT_CNT_W = 16;

   typedef struct packed {
      logic sum;
      logic carry;
   } ha_lane_t;

   // Plain operators on purpose so X/Z on an input propagates unmasked.
   function automatic ha_lane_t ha_eval(input logic a, input logic b);
      ha_lane_t r;
      r.sum   = a ^ b;
      r.carry = a & b;
      return r;
   endfunction

endpackage

// File: rtl/half_adder_bit.sv
// Single-lane combinational half adder cell (a,b -> sum,carry); no state.
module half_adder_bit
   import half_adder_pkg::*;
(
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   ha_lane_t lane;

   assign lane  = ha_eval(a, b);
   assign sum   = lane.sum;
   assign carry = lane.carry;

endmodule

// File: rtl/half_adder.sv
// WIDTH-lane half adder: combinational sum/carry plus a one-cycle registered
// copy with valid. Optional saturating carry-event counter: HALF_ADDER_CARRY_CNT_EN.
module half_adder
   import half_adder_pkg::*;
#(
   parameter int WIDTH = HA_DEFAULT_WIDTH,
   parameter int CNT_W = HA_DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry,
   output logic [WIDTH-1:0] sum_q,
   output logic [WIDTH-1:0] carry_q,
   output logic             out_valid,
   output logic [CNT_W-1:0] carry_cnt
);

   // Lanes are independent cells; nothing ripples between them.
   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      half_adder_bit u_bit (
         .a     (a[i]),
         .b     (b[i]),
         .sum   (sum[i]),
         .carry (carry[i])
      );
   end

   // NOTE: clocked state uses non-blocking (<=) so every register samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q     <= '0;
         carry_q   <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum_q   <= sum;
            carry_q <= carry;
         end
      end
   end

`ifdef HALF_ADDER_CARRY_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt;

   // NOTE: the default assignment first keeps this block purely
   // combinational; a missing default on any path would infer a latch.
   always_comb begin
      cnt_nxt = cnt_r;
      if (in_valid && (|carry) && (cnt_r != CNT_MAX)) begin
         cnt_nxt = cnt_r + CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_nxt;
      end
   end

   assign carry_cnt = cnt_r;
`else
   // Counter removed; port kept so both builds share one interface.
   assign carry_cnt = '0;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: WIDTH=1, WIDTH=8 and CNT_W=2 instances,
// with a scoreboard queue for the WIDTH=1 registered path.
module tb_half_adder;

`ifdef HALF_ADDER_CARRY_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic clk_en = 1'b0;
   logic rst = 1'b0;

   logic        a1 = 1'b0, b1 = 1'b0, v1 = 1'b0;
   logic        s1, c1, sq1, cq1, ov1;
   logic [15:0] cnt1;

   logic [7:0]  a8 = '0, b8 = '0;
   logic        v8 = 1'b0;
   logic [7:0]  s8, c8, sq8, cq8;
   logic        ov8;
   logic [15:0] cnt8;

   logic        ac = 1'b0, bc = 1'b0, vc = 1'b0;
   logic        sc, cc, sqc, cqc, ovc;
   logic [1:0]  cntc;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic s;
      logic c;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   // Truth table indexed by {a,b}: {sum,carry}.
   logic [1:0] tt [4] = '{2'b00, 2'b10, 2'b10, 2'b01};

   always #5 if (clk_en) clk = ~clk;

   half_adder #(.WIDTH(1), .CNT_W(16)) u1 (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1),
      .sum(s1), .carry(c1), .sum_q(sq1), .carry_q(cq1),
      .out_valid(ov1), .carry_cnt(cnt1)
   );

   half_adder #(.WIDTH(8), .CNT_W(16)) u8 (
      .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(v8),
      .sum(s8), .carry(c8), .sum_q(sq8), .carry_q(cq8),
      .out_valid(ov8), .carry_cnt(cnt8)
   );

   half_adder #(.WIDTH(1), .CNT_W(2)) uc (
      .clk(clk), .rst(rst), .a(ac), .b(bc), .in_valid(vc),
      .sum(sc), .carry(cc), .sum_q(sqc), .carry_q(cqc),
      .out_valid(ovc), .carry_cnt(cntc)
   );

   // Scoreboard consumer for u1: one pop per edge with a pending result,
   // otherwise out_valid must be low.
   always @(posedge clk) begin
      #1;
      if (!rst) begin
         checks++;
         if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            if (ov1 !== 1'b1 || sq1 !== mon_e.s || cq1 !== mon_e.c) begin
               errors++;
               $display("FAIL sb_out: got ov=%b sum_q=%b carry_q=%b, want ov=1 sum_q=%b carry_q=%b",
                        ov1, sq1, cq1, mon_e.s, mon_e.c);
            end
         end else if (ov1 !== 1'b0) begin
            errors++;
            $display("FAIL sb_idle: got out_valid=%b, want 0", ov1);
         end
      end
   end

   task automatic drive1(input logic a, input logic b, input logic v);
      @(negedge clk);
      a1 = a;
      b1 = b;
      v1 = v;
      if (v) sb_q.push_back(exp_t'(tt[{a, b}]));
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      checks++;
      if (sq1 !== 1'b0 || cq1 !== 1'b0 || ov1 !== 1'b0 || sq8 !== 8'h00 ||
          cq8 !== 8'h00 || ov8 !== 1'b0 || cntc !== 2'b00 || cnt1 !== 16'h0) begin
         errors++;
         $display("FAIL reset_state: got sq1=%b cq1=%b ov1=%b sq8=%h cq8=%h ov8=%b cntc=%b cnt1=%h, want all 0",
                  sq1, cq1, ov1, sq8, cq8, ov8, cntc, cnt1);
      end
   endtask

   // Clock idle, rst asserted: combinational path must still be correct.
   task automatic test_truth_table();
      for (int i = 0; i < 4; i++) begin
         {a1, b1} = 2'(i);
         #5;
         checks++;
         if ({s1, c1} !== tt[i]) begin
            errors++;
            $display("FAIL truth_%0d: got sum/carry=%b%b, want %b", i, s1, c1, tt[i]);
         end
         #5;
      end
      {a1, b1} = 2'b00;
   endtask

   task automatic test_registered();
      drive1(1'b1, 1'b1, 1'b1);
      drive1(1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #2;
      checks++;
      if (sq1 !== 1'b0 || cq1 !== 1'b1) begin
         errors++;
         $display("FAIL reg_hold: got sum_q=%b carry_q=%b, want 0 1", sq1, cq1);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         drive1(i[1], i[0], 1'b1);
      end
      drive1(1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
   endtask

   task automatic test_vector();
      logic [7:0] va [4] = '{8'hF0, 8'hFF, 8'hAA, 8'hFF};
      logic [7:0] vb [4] = '{8'hCC, 8'h01, 8'h55, 8'hFF};
      logic [7:0] vs [4] = '{8'h3C, 8'hFE, 8'hFF, 8'h00};
      logic [7:0] vcy[4] = '{8'hC0, 8'h01, 8'h00, 8'hFF};
      for (int i = 0; i < 4; i++) begin
         a8 = va[i];
         b8 = vb[i];
         #1;
         checks++;
         if (s8 !== vs[i] || c8 !== vcy[i]) begin
            errors++;
            $display("FAIL vec_comb_%0d: got sum=%h carry=%h, want sum=%h carry=%h",
                     i, s8, c8, vs[i], vcy[i]);
         end
      end
      @(negedge clk);
      a8 = 8'hF0;
      b8 = 8'hCC;
      v8 = 1'b1;
      @(negedge clk);
      a8 = 8'h00;
      b8 = 8'h00;
      v8 = 1'b0;
      #1;
      checks++;
      if (ov8 !== 1'b1 || sq8 !== 8'h3C || cq8 !== 8'hC0) begin
         errors++;
         $display("FAIL vec_reg: got ov=%b sum_q=%h carry_q=%h, want 1 3c c0", ov8, sq8, cq8);
      end
      @(posedge clk);
      #1;
      checks++;
      if (ov8 !== 1'b0 || sq8 !== 8'h3C || cq8 !== 8'hC0) begin
         errors++;
         $display("FAIL vec_hold: got ov=%b sum_q=%h carry_q=%h, want 0 3c c0", ov8, sq8, cq8);
      end
   endtask

   task automatic test_counter();
      // Rows of {a,b,in_valid}.
      logic [2:0] steps [10] = '{3'b110, 3'b111, 3'b101, 3'b111, 3'b111,
                                 3'b111, 3'b111, 3'b111, 3'b101, 3'b000};
      int exp_cnt = 0;
      logic [1:0] want;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         {ac, bc, vc} = steps[i];
         if (vc && ac && bc && exp_cnt < 3) exp_cnt++;
         @(posedge clk);
         #1;
         want = CNT_EN ? 2'(exp_cnt) : 2'b00;
         checks++;
         if (cntc !== want) begin
            errors++;
            $display("FAIL cnt_step_%0d: got carry_cnt=%0d, want %0d", i, cntc, want);
         end
      end
   endtask

   task automatic test_async_reset();
      drive1(1'b1, 1'b0, 1'b1);
      drive1(1'b1, 1'b1, 1'b1);
      #2;
      // out_valid is high from the previous capture; the second result is in flight.
      rst = 1'b1;
      sb_q.delete();
      #1;
      checks++;
      if (sq1 !== 1'b0 || cq1 !== 1'b0 || ov1 !== 1'b0 || sq8 !== 8'h00 ||
          cq8 !== 8'h00 || cntc !== 2'b00) begin
         errors++;
         $display("FAIL async_rst: got sq1=%b cq1=%b ov1=%b sq8=%h cq8=%h cntc=%b, want all 0",
                  sq1, cq1, ov1, sq8, cq8, cntc);
      end
      checks++;
      if (s1 !== 1'b0 || c1 !== 1'b1) begin
         errors++;
         $display("FAIL comb_in_rst: got sum=%b carry=%b, want 0 1", s1, c1);
      end
      @(negedge clk);
      v1 = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (ov1 !== 1'b0 || sq1 !== 1'b0) begin
         errors++;
         $display("FAIL rst_hold: got ov=%b sum_q=%b, want 0 0", ov1, sq1);
      end
      @(negedge clk);
      rst = 1'b0;
      drive1(1'b0, 1'b1, 1'b1);
      drive1(1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      #1;
      test_reset();
      test_truth_table();
      clk_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      test_registered();
      test_back_to_back();
      test_vector();
      test_counter();
      test_async_reset();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d pending results, want 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
